mpu_axis_filter: RTL

//  Consumes the MPU6050 sequencer byte stream (LOAD/ADR/DATA/COMPLETED), assembles signed 16-bit X/Y/Z

---
 rtl/mpu_axis_filter.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/mpu_axis_filter.sv
// rtl/mpu_axis_filter.sv - MPU6050 accel byte assembler, per-axis IIR low-pass and dominant tilt classifier
// Define MPU_IIR_EN to build the IIR accumulators; otherwise XF/YF/ZF carry the raw samples.
module mpu_axis_filter #(
  parameter int          K      = 3,
  parameter logic [15:0] THRESH = 16'd4096
) (
  input  logic        MCLK,
  input  logic        nRST,
  input  logic        TIC,
  input  logic        LOAD,
  input  logic [3:0]  ADR,
  input  logic [7:0]  DATA,
  input  logic        COMPLETED,
  output logic        RESCAN,
  output logic [15:0] XF,
  output logic [15:0] YF,
  output logic [15:0] ZF,
  output logic [1:0]  DOM_AXIS,
  output logic        DOM_SIGN,
  output logic        SAMPLE_VALID,
  output logic [7:0]  FRAME_ERR
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_FX   = 3'd1;
  localparam logic [2:0] ST_FY   = 3'd2;
  localparam logic [2:0] ST_FZ   = 3'd3;
  localparam logic [2:0] ST_CLS  = 3'd4;
  localparam logic [2:0] ST_RSC  = 3'd5;

  logic [2:0]  state_q, state_d;
  logic [5:0]  mask_q, mask_d;
  logic [47:0] raw_q, raw_d;
  logic [15:0] xf_q, xf_d, yf_q, yf_d, zf_q, zf_d;
  logic [1:0]  dom_axis_q, dom_axis_d;
  logic        dom_sign_q, dom_sign_d;
  logic        sample_valid_q, sample_valid_d;
  logic        rescan_q, rescan_d;
  logic [7:0]  frame_err_q, frame_err_d;

  // Byte slot n lives at raw[8n +: 8]; even slots are the high bytes.
  logic [15:0] x_raw, y_raw, z_raw;
  assign x_raw = {raw_q[7:0],   raw_q[15:8]};
  assign y_raw = {raw_q[23:16], raw_q[31:24]};
  assign z_raw = {raw_q[39:32], raw_q[47:40]};

  logic [15:0] x_next, y_next, z_next;

`ifdef MPU_IIR_EN
  localparam int AW = 16 + K;

  logic signed [AW-1:0] acc_x_q, acc_x_d, acc_y_q, acc_y_d, acc_z_q, acc_z_d;
  logic signed [AW-1:0] acc_x_n, acc_y_n, acc_z_n;
  logic                 seeded_q, seeded_d;

  // Unseeded accumulators jump straight to x<<<K so the first output equals the sample.
  function automatic logic signed [AW-1:0] iir_step(input logic signed [AW-1:0] acc,
                                                    input logic [15:0] x,
                                                    input logic seeded);
    logic signed [AW-1:0] xe;
    xe = {{K{x[15]}}, x};
    if (!seeded) return xe <<< K;
    return acc + xe - (acc >>> K);
  endfunction

  function automatic logic [15:0] iir_out(input logic signed [AW-1:0] acc);
    logic signed [AW-1:0] sh;
    sh = acc >>> K;
    return sh[15:0];
  endfunction

  always_comb begin
    acc_x_n = iir_step(acc_x_q, x_raw, seeded_q);
    acc_y_n = iir_step(acc_y_q, y_raw, seeded_q);
    acc_z_n = iir_step(acc_z_q, z_raw, seeded_q);
  end

  assign x_next = iir_out(acc_x_n);
  assign y_next = iir_out(acc_y_n);
  assign z_next = iir_out(acc_z_n);

  always_comb begin
    acc_x_d  = acc_x_q;
    acc_y_d  = acc_y_q;
    acc_z_d  = acc_z_q;
    seeded_d = seeded_q;
    if (TIC) begin
      case (state_q)
        ST_FX:   acc_x_d = acc_x_n;
        ST_FY:   acc_y_d = acc_y_n;
        ST_FZ: begin
          acc_z_d  = acc_z_n;
          seeded_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge MCLK or negedge nRST) begin
    if (!nRST) begin
      acc_x_q  <= '0;
      acc_y_q  <= '0;
      acc_z_q  <= '0;
      seeded_q <= 1'b0;
    end else begin
      acc_x_q  <= acc_x_d;
      acc_y_q  <= acc_y_d;
      acc_z_q  <= acc_z_d;
      seeded_q <= seeded_d;
    end
  end
`else
  logic k_unused;
  assign k_unused = (K > 0);
  assign x_next   = x_raw;
  assign y_next   = y_raw;
  assign z_next   = z_raw;
`endif

  function automatic logic [15:0] sat_abs(input logic [15:0] v);
    if (v == 16'h8000) return 16'h7FFF;
    return v[15] ? -v : v;
  endfunction

  logic [15:0] abs_x, abs_y, abs_z, win_abs;
  logic [1:0]  win_axis;
  logic        win_sign;

  // Non-strict compares give X priority over Y over Z on equal magnitudes.
  always_comb begin
    abs_x = sat_abs(xf_q);
    abs_y = sat_abs(yf_q);
    abs_z = sat_abs(zf_q);
    if (abs_x >= abs_y && abs_x >= abs_z) begin
      win_axis = 2'b01;
      win_abs  = abs_x;
      win_sign = xf_q[15];
    end else if (abs_y >= abs_z) begin
      win_axis = 2'b10;
      win_abs  = abs_y;
      win_sign = yf_q[15];
    end else begin
      win_axis = 2'b11;
      win_abs  = abs_z;
      win_sign = zf_q[15];
    end
  end

  always_comb begin
    state_d        = state_q;
    mask_d         = mask_q;
    raw_d          = raw_q;
    xf_d           = xf_q;
    yf_d           = yf_q;
    zf_d           = zf_q;
    dom_axis_d     = dom_axis_q;
    dom_sign_d     = dom_sign_q;
    sample_valid_d = 1'b0;
    rescan_d       = rescan_q;
    frame_err_d    = frame_err_q;
    if (TIC) begin
      case (state_q)
        ST_IDLE: begin
          if (LOAD && ADR <= 4'd5) begin
            raw_d[{ADR[2:0], 3'b000} +: 8] = DATA;
            mask_d[ADR[2:0]]               = 1'b1;
          end
          // mask_d already includes a byte captured on this same TIC.
          if (COMPLETED) begin
            if (mask_d == 6'h3F) begin
              state_d = ST_FX;
            end else begin
              state_d  = ST_RSC;
              rescan_d = 1'b1;
              if (frame_err_q != 8'hFF) frame_err_d = frame_err_q + 8'd1;
            end
          end
        end
        ST_FX: begin
          xf_d    = x_next;
          state_d = ST_FY;
        end
        ST_FY: begin
          yf_d    = y_next;
          state_d = ST_FZ;
        end
        ST_FZ: begin
          zf_d    = z_next;
          state_d = ST_CLS;
        end
        ST_CLS: begin
          if (win_abs < THRESH) begin
            dom_axis_d = 2'b00;
            dom_sign_d = 1'b0;
          end else begin
            dom_axis_d = win_axis;
            dom_sign_d = win_sign;
          end
          sample_valid_d = 1'b1;
          rescan_d       = 1'b1;
          state_d        = ST_RSC;
        end
        ST_RSC: begin
          rescan_d = 1'b0;
          mask_d   = 6'h00;
          state_d  = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge MCLK or negedge nRST) begin
    if (!nRST) begin
      state_q        <= ST_IDLE;
      mask_q         <= '0;
      raw_q          <= '0;
      xf_q           <= '0;
      yf_q           <= '0;
      zf_q           <= '0;
      dom_axis_q     <= '0;
      dom_sign_q     <= 1'b0;
      sample_valid_q <= 1'b0;
      rescan_q       <= 1'b0;
      frame_err_q    <= '0;
    end else begin
      state_q        <= state_d;
      mask_q         <= mask_d;
      raw_q          <= raw_d;
      xf_q           <= xf_d;
      yf_q           <= yf_d;
      zf_q           <= zf_d;
      dom_axis_q     <= dom_axis_d;
      dom_sign_q     <= dom_sign_d;
      sample_valid_q <= sample_valid_d;
      rescan_q       <= rescan_d;
      frame_err_q    <= frame_err_d;
    end
  end

  assign RESCAN       = rescan_q;
  assign XF           = xf_q;
  assign YF           = yf_q;
  assign ZF           = zf_q;
  assign DOM_AXIS     = dom_axis_q;
  assign DOM_SIGN     = dom_sign_q;
  assign SAMPLE_VALID = sample_valid_q;
  assign FRAME_ERR    = frame_err_q;

endmodule
